// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN feature-map pipeline:
//   - default pixel width and the feature-map dimensions along the chain
//     (28x28 input image -> 26x26 convolution result -> 13x13 pooled map);
//   - the state encoding of the ReLU/max-pool row sequencer;
//   - a width-agnostic signed maximum. Callers sign-extend into MAX_W bits
//     and truncate the result back to their own width.
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int BIT_DEPTH    = 16;
  localparam int FMAP_IN_DIM  = 28;
  localparam int CONV_OUT_DIM = FMAP_IN_DIM - 2;
  localparam int POOL_OUT_DIM = CONV_OUT_DIM / 2;

  // Widest pixel the signed-max helper accepts.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2
  } pool_state_e;

  function automatic logic signed [MAX_W-1:0] smax(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// -----------------------------------------------------------------------------
// pool_line_buffer
// Holds the horizontal pair maxima of the most recent even row, one entry per
// output column. One synchronous write port, one asynchronous read port; both
// are addressed by col>>1. Maps to distributed RAM.
//
// Ports:
//   clk    - clock, write on posedge
//   we     - write enable
//   waddr  - write address (output column)
//   wdata  - horizontal pair maximum to store
//   raddr  - read address (output column)
//   rdata  - stored pair maximum, combinational read
// -----------------------------------------------------------------------------
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int depth  = POOL_OUT_DIM,
  parameter int width  = BIT_DEPTH,
  parameter int addr_w = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [width-1:0]  wdata,
  input  logic [addr_w-1:0] raddr,
  output logic [width-1:0]  rdata
);

  logic [width-1:0] mem [depth];

  // NOTE: storage arrays get no reset; every entry read in an odd row was
  // written earlier in the preceding even row, and a reset port would block
  // mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool_layer.sv
// -----------------------------------------------------------------------------
// relu_maxpool_layer
// ReLU followed by 2x2 / stride-2 max-pooling over a raster-order pixel
// stream. Even rows fold each column pair into a line buffer; odd rows fold
// their own column pair and combine it with the buffered value, emitting one
// pooled pixel one clock after the beat that completes the 2x2 window.
// An odd trailing column of each row and an odd trailing row of the frame are
// dropped.
//
// Build option: define POOL_RELU_EN to clamp negative inputs to zero before
// pooling; without it the block is a pure signed max-pool.
//
// Ports:
//   clk       - clock, all logic on posedge
//   RESET     - synchronous active-high reset
//   in_valid  - in_data carries a pixel this cycle
//   in_sof    - with in_valid, marks pixel (row 0, col 0); restarts the frame
//   in_data   - signed input pixel
//   out_valid - one-cycle pulse per pooled pixel
//   out_data  - signed pooled pixel (held between pulses)
//   out_last  - with out_valid, final pooled pixel of the frame
//   busy      - a frame is in progress
// -----------------------------------------------------------------------------
module relu_maxpool_layer
  import cnn_pkg::*;
#(
  parameter int bit_depth = BIT_DEPTH,
  parameter int in_width  = CONV_OUT_DIM,
  parameter int in_height = CONV_OUT_DIM
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [bit_depth-1:0] in_data,
  output logic                 out_valid,
  output logic [bit_depth-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int COL_W     = $clog2(in_width);
  localparam int ROW_W     = $clog2(in_height);
  localparam int BUF_DEPTH = in_width / 2;
  localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  // Last column/row that takes part in pooling (odd remainders are dropped).
  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(in_width - 1);
  localparam logic [COL_W-1:0] LAST_ODD_COL = COL_W'(in_width - (in_width % 2) - 1);
  localparam logic [ROW_W-1:0] LAST_ODD_ROW = ROW_W'(in_height - (in_height % 2) - 1);

  pool_state_e                 state, state_next;
  logic [COL_W-1:0]            col, col_next;
  logic [ROW_W-1:0]            row, row_next;
  logic signed [bit_depth-1:0] pair, pair_next;
  logic signed [bit_depth-1:0] pix;
  logic signed [bit_depth-1:0] pair_max;
  logic signed [bit_depth-1:0] pool_max;
  logic signed [bit_depth-1:0] buf_rdata;
  logic [BUF_AW-1:0]           buf_addr;
  logic                        buf_we;
  logic                        emit;
  logic                        emit_last;

`ifdef POOL_RELU_EN
  assign pix = in_data[bit_depth-1] ? '0 : $signed(in_data);
`else
  assign pix = $signed(in_data);
`endif

  // Horizontal pair maximum, then the full 2x2 maximum against the even row.
  assign pair_max = bit_depth'(smax(MAX_W'(pair), MAX_W'(pix)));
  assign pool_max = bit_depth'(smax(MAX_W'(pair_max), MAX_W'(buf_rdata)));
  assign buf_addr = BUF_AW'(col >> 1);

  pool_line_buffer #(
    .depth  (BUF_DEPTH),
    .width  (bit_depth),
    .addr_w (BUF_AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (pair_max),
    .raddr (buf_addr),
    .rdata (buf_rdata)
  );

  // NOTE: every signal written here is given a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    pair_next  = pair;
    buf_we     = 1'b0;
    emit       = 1'b0;
    emit_last  = 1'b0;

    if (in_valid) begin
      if (in_sof) begin
        // Start (or restart) a frame; this beat is col 0 of row 0.
        state_next = EVEN_ROW;
        col_next   = COL_W'(1);
        row_next   = '0;
        pair_next  = pix;
      end else if (state != IDLE) begin
        if (!col[0]) begin
          pair_next = pix;
        end else if (state == EVEN_ROW) begin
          buf_we = 1'b1;
        end else begin
          emit      = 1'b1;
          emit_last = (row == LAST_ODD_ROW) && (col == LAST_ODD_COL);
        end

        if (col == COL_LAST) begin
          col_next = '0;
          if (state == EVEN_ROW) begin
            state_next = ODD_ROW;
            row_next   = row + ROW_W'(1);
          end else if (row == LAST_ODD_ROW) begin
            // Any trailing odd row arrives while IDLE and is ignored.
            state_next = IDLE;
            row_next   = '0;
          end else begin
            state_next = EVEN_ROW;
            row_next   = row + ROW_W'(1);
          end
        end else begin
          col_next = col + COL_W'(1);
        end
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      pair      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_next;
      col       <= col_next;
      row       <= row_next;
      pair      <= pair_next;
      out_valid <= emit;
      out_last  <= emit_last;
      if (emit) begin
        out_data <= pool_max;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
